hs_rsp_fis_rx: RTL and testbench
================================

// Module: hs_rsp_fis_rx
// PURPOSE
//  Upstream feeder of the host-side response interface. Parses Device-to-Host FIS dwords from the
//  transport receive stream and writes response FISes into the response buffer (rsp_we/waddr/wdata).
//  Pulses rsp_done after a complete, length-checked, CRC-clean FIS, then blocks further response FISes
//  until the host acknowledges. Non-response or bad FISes are dropped and counted.
// PARAMETERS
//  C_RSP_BASE  5'd0   rsp_waddr of FIS dword 0; dword i is written at C_RSP_BASE+i (5-bit wrap)
//  C_CNT_W     8      width of saturating drop counter
// PORTS
//  sys_clk      in   1        single clock
//  sys_rst      in   1        synchronous, active-high reset
//  rx_data      in   32       FIS dword; dword 0 bits[7:0] = FIS type
//  rx_valid     in   1        rx_data valid; transfer when rx_valid & rx_ready
//  rx_sof       in   1        first dword of FIS (qualified by transfer)
//  rx_eof       in   1        last dword of FIS (qualified by transfer)
//  rx_crc_err   in   1        CRC/link error for this FIS, valid with rx_eof
//  rx_ready     out  1        stream backpressure
//  rsp_ack      in   1        host acknowledge of pending response (wired to RspAck)
//  rsp_we       out  1        response buffer write strobe
//  rsp_waddr    out  5        response buffer dword address
//  rsp_wdata    out  32       response buffer write data
//  rsp_done     out  1        1-cycle pulse: response FIS complete in buffer
//  rsp_pend     out  1        response delivered, awaiting rsp_ack
//  drop_cnt     out  C_CNT_W  saturating count of dropped FISes
// BEHAVIOUR
//  Reset: state IDLE; rx_ready=1, rsp_we=0, rsp_waddr=C_RSP_BASE, rsp_wdata=0, rsp_done=0,
//   rsp_pend=0, drop_cnt=0. Reset mid-FIS discards it; no rsp_done, no count.
//  Accepted types / exact dword lengths: 0x34 D2H Reg = 5, 0x5F PIO Setup = 5, 0xA1 Set Device Bits = 2.
//  Any other type (e.g. 0x39 DMA Activate, 0x41 DMA Setup, 0x46 Data) -> DROP.
//  States: IDLE, BODY, DROP, DONE, WAIT_ACK.
//   IDLE: on transfer with rx_sof: accepted type -> write dword 0, cnt=1, go BODY (DONE directly if
//    rx_eof and len ok). Unaccepted type -> DROP. Transfer without rx_sof is ignored, not counted.
//   BODY: each transfer writes at C_RSP_BASE+cnt, cnt++. On rx_eof: (cnt+1==len & !rx_crc_err) -> DONE,
//    else drop_cnt++ and -> IDLE. cnt reaching len without eof -> DROP (overlong); rx_sof seen -> count
//    drop, restart parse with this dword as dword 0.
//   DROP: consume without writing until rx_eof transfer; drop_cnt++ (once per FIS) -> IDLE.
//   DONE: rsp_done=1 one cycle; rsp_pend<=1 -> WAIT_ACK.
//   WAIT_ACK: rx_ready=0; on rsp_ack -> rsp_pend<=0, IDLE the next cycle. rsp_ack outside WAIT_ACK ignored.
//  Write path registered: rsp_we/waddr/wdata appear 1 cycle after the accepting transfer; rsp_done
//   is 1 cycle after the final rsp_we (last-dword write always precedes rsp_done).
//  rx_ready=1 in IDLE, BODY, DROP; 0 in DONE and WAIT_ACK. A dropped or bad FIS may leave partial
//   buffer contents; these are valid only after rsp_done.
//  drop_cnt saturates at all-ones. Addresses wrap mod 32.
//  Simultaneous rsp_ack with DONE: impossible by construction (ack sampled only in WAIT_ACK).
// STRUCTURE
//  Shared package/header: FIS type codes (FIS_D2H=8'h34, FIS_PIO=8'h5F, FIS_SDB=8'hA1) and their
//   lengths, state encodings. Single module; no sub-module.
// TESTING
//  D2H 0x34 5 dwords, no CRC err -> 5 writes addr 0..4 data match, rsp_done 1 cycle after 5th write,
//   rx_ready low until rsp_ack.
//  SDB 0xA1 2 dwords, then 2nd SDB offered before ack -> second held (rx_ready=0), accepted after
//   rsp_ack, two rsp_done total.
//  D2H with rx_crc_err at eof -> no rsp_done, drop_cnt=1.
//  D2H of 4 dwords (short) and of 7 dwords (long) -> no rsp_done, drop_cnt=2, no writes past addr 4.
//  DMA Activate 0x39 1 dword -> no rsp_we, drop_cnt=1; 300 such -> drop_cnt=255.
//  sys_rst asserted after dword 2 of PIO Setup -> all outputs reset values, next clean FIS completes.

Source files
------------

// File: rtl/hs_rsp_fis_rx_pkg.sv
// Shared definitions for the D2H response FIS receiver: FIS type codes,
// their exact dword lengths, and parser state encodings.
package hs_rsp_fis_rx_pkg;

  localparam logic [7:0] FIS_D2H = 8'h34;
  localparam logic [7:0] FIS_PIO = 8'h5F;
  localparam logic [7:0] FIS_SDB = 8'hA1;

  localparam logic [2:0] LEN_D2H = 3'd5;
  localparam logic [2:0] LEN_PIO = 3'd5;
  localparam logic [2:0] LEN_SDB = 3'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BODY,
    S_DROP,
    S_DONE,
    S_WAIT_ACK
  } state_e;

  // Zero length marks a FIS type this block does not deliver to the host.
  function automatic logic [2:0] fis_len(input logic [7:0] fis_type);
    case (fis_type)
      FIS_D2H: fis_len = LEN_D2H;
      FIS_PIO: fis_len = LEN_PIO;
      FIS_SDB: fis_len = LEN_SDB;
      default: fis_len = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/hs_rsp_fis_rx_if.sv
// Transport receive stream carrying FIS dwords into the response parser.
interface hs_rsp_fis_rx_if;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_sof;
  logic        rx_eof;
  logic        rx_crc_err;
  logic        rx_ready;

  modport master (output rx_data, rx_valid, rx_sof, rx_eof, rx_crc_err, input rx_ready);
  modport slave  (input rx_data, rx_valid, rx_sof, rx_eof, rx_crc_err, output rx_ready);
endinterface

// File: rtl/hs_rsp_fis_rx.sv
// Parses D2H FISes from the receive stream into the response buffer; signals
// completion of clean responses and holds off new ones until the host acks.
module hs_rsp_fis_rx
  import hs_rsp_fis_rx_pkg::*;
#(
  parameter logic [4:0] C_RSP_BASE = 5'd0,
  parameter int         C_CNT_W    = 8
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  hs_rsp_fis_rx_if.slave     rx,
  input  logic               rsp_ack,
  output logic               rsp_we,
  output logic [4:0]         rsp_waddr,
  output logic [31:0]        rsp_wdata,
  output logic               rsp_done,
  output logic               rsp_pend,
  output logic [C_CNT_W-1:0] drop_cnt
);

  state_e     state;
  logic [2:0] cnt;
  logic [2:0] len;

  logic       xfer;
  logic [2:0] hdr_len;
  logic       hdr_ok;
  logic       start_drop;
  logic       last;

  assign rx.rx_ready = (state == S_IDLE) || (state == S_BODY) || (state == S_DROP);
  assign xfer        = rx.rx_valid && rx.rx_ready;
  assign hdr_len     = fis_len(rx.rx_data[7:0]);
  assign hdr_ok      = (hdr_len != 3'd0);
  // A header dword that is also eof completes only for a clean 1-dword type.
  assign start_drop  = rx.rx_eof && !(hdr_ok && hdr_len == 3'd1 && !rx.rx_crc_err);
  assign last        = (3'(cnt + 3'd1) == len);

  function automatic logic [C_CNT_W-1:0] sat_add(input logic [C_CNT_W-1:0] c,
                                                  input logic [1:0] n);
    logic [C_CNT_W:0] s;
    s = {1'b0, c} + (C_CNT_W + 1)'(n);
    sat_add = s[C_CNT_W] ? '1 : s[C_CNT_W-1:0];
  endfunction

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= S_IDLE;
      cnt       <= 3'd0;
      len       <= 3'd0;
      rsp_we    <= 1'b0;
      rsp_waddr <= C_RSP_BASE;
      rsp_wdata <= 32'd0;
      rsp_done  <= 1'b0;
      rsp_pend  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      rsp_we   <= 1'b0;
      rsp_done <= 1'b0;
      case (state)
        S_IDLE, S_BODY: begin
          if (xfer && rx.rx_sof) begin
            // sof inside BODY aborts the current FIS and reparses this dword.
            drop_cnt <= sat_add(drop_cnt, {1'b0, state == S_BODY} + {1'b0, start_drop});
            if (hdr_ok) begin
              rsp_we    <= 1'b1;
              rsp_waddr <= C_RSP_BASE;
              rsp_wdata <= rx.rx_data;
              cnt       <= 3'd1;
              len       <= hdr_len;
            end
            if (!rx.rx_eof) state <= hdr_ok ? S_BODY : S_DROP;
            else            state <= start_drop ? S_IDLE : S_DONE;
          end else if (xfer && state == S_BODY) begin
            rsp_we    <= 1'b1;
            rsp_waddr <= C_RSP_BASE + {2'b00, cnt};
            rsp_wdata <= rx.rx_data;
            cnt       <= cnt + 3'd1;
            if (rx.rx_eof) begin
              if (last && !rx.rx_crc_err) begin
                state <= S_DONE;
              end else begin
                drop_cnt <= sat_add(drop_cnt, 2'd1);
                state    <= S_IDLE;
              end
            end else if (last) begin
              state <= S_DROP;
            end
          end
        end
        S_DROP: begin
          if (xfer && rx.rx_eof) begin
            drop_cnt <= sat_add(drop_cnt, 2'd1);
            state    <= S_IDLE;
          end
        end
        S_DONE: begin
          rsp_done <= 1'b1;
          rsp_pend <= 1'b1;
          state    <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (rsp_ack) begin
            rsp_pend <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hs_rsp_fis_rx.sv
// Scoreboard bench for hs_rsp_fis_rx: directed FIS traffic pushes expected
// buffer writes/completions; a negedge monitor pops and compares them.
module tb_hs_rsp_fis_rx;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        rsp_ack;
  logic        rsp_we;
  logic [4:0]  rsp_waddr;
  logic [31:0] rsp_wdata;
  logic        rsp_done;
  logic        rsp_pend;
  logic [7:0]  drop_cnt;

  hs_rsp_fis_rx_if rx_bus ();

  hs_rsp_fis_rx #(.C_RSP_BASE(5'd0), .C_CNT_W(8)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .rx       (rx_bus),
    .rsp_ack  (rsp_ack),
    .rsp_we   (rsp_we),
    .rsp_waddr(rsp_waddr),
    .rsp_wdata(rsp_wdata),
    .rsp_done (rsp_done),
    .rsp_pend (rsp_pend),
    .drop_cnt (drop_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int failures = 0;
  int done_seen = 0;
  int done_exp = 0;
  logic [36:0] wr_q[$];
  bit          done_q[$];
  logic        prev_we = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write and completion must match a scoreboard entry.
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (rsp_we) begin
        if (wr_q.size() == 0) chk("unexpected_write", {rsp_waddr, rsp_wdata}, 64'h0);
        else chk("write", {27'd0, rsp_waddr, rsp_wdata}, {27'd0, wr_q.pop_front()});
      end
      if (rsp_done) begin
        done_seen++;
        if (done_q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
        else begin
          void'(done_q.pop_front());
          chk("done_after_last_write", {63'd0, prev_we}, 64'd1);
          chk("done_rx_ready_low", {63'd0, rx_bus.rx_ready}, 64'd0);
        end
      end
    end
    prev_we = rsp_we;
  end

  task automatic mk(input logic [7:0] t, input int seed, output logic [31:0] w[8]);
    for (int i = 0; i < 8; i++)
      w[i] = (i == 0) ? {8'(seed), 16'h5A00, t} : {8'hC0 + 8'(seed), 16'h0000, 8'(i)};
  endtask

  // Sends the first nsend dwords of an n-dword FIS (eof on dword n-1).
  task automatic send_fis(input logic [31:0] w[8], input int n, input int nsend,
                          input logic crc, input int nwr, input bit good);
    int to;
    for (int i = 0; i < nwr; i++) wr_q.push_back({5'(i), w[i]});
    if (good) begin done_q.push_back(1'b1); done_exp++; end
    for (int i = 0; i < nsend; i++) begin
      rx_bus.rx_valid   = 1'b1;
      rx_bus.rx_data    = w[i];
      rx_bus.rx_sof     = (i == 0);
      rx_bus.rx_eof     = (i == n - 1);
      rx_bus.rx_crc_err = (i == n - 1) ? crc : 1'b0;
      to = 0;
      while (!rx_bus.rx_ready && to < 200) begin
        @(posedge sys_clk); #1; to++;
      end
      if (to >= 200) begin
        chk("rx_ready_timeout", 64'd0, 64'd1);
        rx_bus.rx_valid = 1'b0;
        return;
      end
      @(posedge sys_clk); #1;
    end
    rx_bus.rx_valid = 1'b0;
    rx_bus.rx_sof   = 1'b0;
    rx_bus.rx_eof   = 1'b0;
  endtask

  task automatic wait_pend();
    int to = 0;
    @(negedge sys_clk);
    while (!rsp_pend && to < 50) begin @(negedge sys_clk); to++; end
    chk("pend_set", {63'd0, rsp_pend}, 64'd1);
  endtask

  task automatic ack_rsp();
    @(posedge sys_clk); #1 rsp_ack = 1'b1;
    @(posedge sys_clk); #1 rsp_ack = 1'b0;
    @(negedge sys_clk);
    chk("pend_cleared", {62'd0, rsp_pend, rx_bus.rx_ready}, 64'b01);
  endtask

  task automatic do_reset();
    @(posedge sys_clk); #1;
    sys_rst = 1'b1;
    rx_bus.rx_valid = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("reset_state", {rx_bus.rx_ready, rsp_we, rsp_waddr, rsp_wdata, rsp_done, rsp_pend, drop_cnt},
        {1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 8'd0});
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  logic [31:0] w[8];
  logic [31:0] w2[8];

  initial begin
    sys_rst = 1'b1;
    rsp_ack = 1'b0;
    rx_bus.rx_valid = 1'b0;
    rx_bus.rx_data = 32'd0;
    rx_bus.rx_sof = 1'b0;
    rx_bus.rx_eof = 1'b0;
    rx_bus.rx_crc_err = 1'b0;
    do_reset();

    // Clean D2H: 5 writes, done, ready held low until ack.
    mk(8'h34, 1, w);
    send_fis(w, 5, 5, 1'b0, 5, 1'b1);
    wait_pend();
    idle(3);
    chk("d2h_hold_ready", {62'd0, rsp_pend, rx_bus.rx_ready}, 64'b10);
    ack_rsp();
    chk("d2h_done_count", 64'(done_seen), 64'd1);

    // SDB, then a second SDB offered while the first is pending.
    mk(8'hA1, 2, w);
    send_fis(w, 2, 2, 1'b0, 2, 1'b1);
    wait_pend();
    mk(8'hA1, 3, w2);
    fork
      send_fis(w2, 2, 2, 1'b0, 2, 1'b1);
      begin
        idle(4);
        chk("sdb2_held", {62'd0, rsp_pend, rx_bus.rx_ready}, 64'b10);
        chk("sdb2_not_written", 64'(wr_q.size()), 64'd2);
        ack_rsp();
      end
    join
    wait_pend();
    ack_rsp();
    chk("sdb_done_count", 64'(done_seen), 64'd3);
    chk("no_drops_yet", 64'(drop_cnt), 64'd0);

    // CRC error at eof.
    do_reset();
    mk(8'h34, 4, w);
    send_fis(w, 5, 5, 1'b1, 5, 1'b0);
    idle(4);
    chk("crc_drop", {55'd0, rsp_pend, drop_cnt}, {55'd0, 1'b0, 8'd1});

    // Short and long D2H.
    do_reset();
    mk(8'h34, 5, w);
    send_fis(w, 4, 4, 1'b0, 4, 1'b0);
    idle(2);
    chk("short_drop", 64'(drop_cnt), 64'd1);
    mk(8'h34, 6, w);
    send_fis(w, 7, 7, 1'b0, 5, 1'b0);
    idle(4);
    chk("long_drop", {55'd0, rsp_pend, drop_cnt}, {55'd0, 1'b0, 8'd2});

    // Unaccepted type, then saturation.
    do_reset();
    mk(8'h39, 7, w);
    send_fis(w, 1, 1, 1'b0, 0, 1'b0);
    idle(2);
    chk("dma_act_drop", 64'(drop_cnt), 64'd1);
    for (int k = 0; k < 299; k++) send_fis(w, 1, 1, 1'b0, 0, 1'b0);
    idle(2);
    chk("drop_saturate", 64'(drop_cnt), 64'd255);

    // Reset in the middle of a PIO Setup, then a clean PIO Setup.
    do_reset();
    mk(8'h5F, 8, w);
    send_fis(w, 5, 2, 1'b0, 2, 1'b0);
    do_reset();
    chk("midfis_no_writes_left", 64'(wr_q.size()), 64'd0);
    mk(8'h5F, 9, w);
    send_fis(w, 5, 5, 1'b0, 5, 1'b1);
    wait_pend();
    ack_rsp();
    chk("pio_after_reset_drop", 64'(drop_cnt), 64'd0);

    idle(4);
    chk("total_done", 64'(done_seen), 64'(done_exp));
    chk("queues_empty", 64'(wr_q.size() + done_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
